fp_div_iter: RTL and testbench

Sequential, parametrised IEEE-754 floating-point divider, the multi-cycle successor to the combinational double-precision divider in the D-extension ALU. It supports any binary format through `EXP_W`/`FRAC_W` (double and single are the required configurations) and divides with a radix-2 restoring iteration, one quotient bit per cycle. It adds a valid/ready handshake, all five RISC-V rounding modes, RISC-V `fflags` reporting and subnormal-input normalisation. The block sits behind the ALU issue logic and holds at most one operation in flight.

---
 rtl/fp_div_iter.sv | 262 ++++++++++++++++++++++++++
 tb/tb_fp_div_iter.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_div_iter.sv
// Multi-cycle IEEE-754 divider: radix-2 restoring iteration, one quotient bit per cycle,
// valid/ready handshake, five RISC-V rounding modes and fflags {NV,DZ,OF,UF,NX}.
module fp_div_iter #(
   parameter int EXP_W  = 11,
   parameter int FRAC_W = 52
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [EXP_W+FRAC_W:0] a,
   input  logic [EXP_W+FRAC_W:0] b,
   input  logic [2:0]            rm,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [EXP_W+FRAC_W:0] result,
   output logic [4:0]            flags
);

   localparam int M     = FRAC_W + 1;
   localparam int W     = 1 + EXP_W + FRAC_W;
   localparam int XW    = EXP_W + 3;
   localparam int CNT_W = $clog2(M + 2);
   localparam int BIAS  = (1 << (EXP_W - 1)) - 1;

   typedef enum logic [2:0] {S_IDLE, S_PRE, S_DIV, S_ROUND, S_DONE} state_t;

   state_t             state_q, state_d;
   logic [W-1:0]       a_q, a_d, b_q, b_d;
   logic [2:0]         rm_q, rm_d;
   logic [XW-1:0]      exp_q, exp_d;
   logic [M-1:0]       mb_q, mb_d;
   logic [M:0]         rem_q, rem_d;
   logic [M+1:0]       quo_q, quo_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               special_q, special_d;
   logic [W-1:0]       result_q, result_d;
   logic [4:0]         flags_q, flags_d;

   function automatic logic [XW-1:0] lzc(input logic [M-1:0] v);
      lzc = XW'(M);
      for (int unsigned i = 0; i < M; i++) begin
         if (v[i]) lzc = XW'(M - 1 - i);
      end
   endfunction

   // Operand classification and subnormal normalisation
   logic               sign_r;
   logic [EXP_W-1:0]   ea_f, eb_f;
   logic [FRAC_W-1:0]  fa_f, fb_f;
   logic               nan_a, nan_b, snan_a, snan_b, inf_a, inf_b, zero_a, zero_b;
   logic [M-1:0]       sa_raw, sb_raw, ma_n, mb_n;
   logic [XW-1:0]      la, lb, ea_eff, eb_eff, exp_pre;
   logic               ma_lt;
   logic [M:0]         rem_pre;

   always_comb begin
      sign_r  = a_q[W-1] ^ b_q[W-1];
      ea_f    = a_q[W-2:FRAC_W];
      eb_f    = b_q[W-2:FRAC_W];
      fa_f    = a_q[FRAC_W-1:0];
      fb_f    = b_q[FRAC_W-1:0];
      nan_a   = (&ea_f) & (|fa_f);
      nan_b   = (&eb_f) & (|fb_f);
      snan_a  = nan_a & ~fa_f[FRAC_W-1];
      snan_b  = nan_b & ~fb_f[FRAC_W-1];
      inf_a   = (&ea_f) & ~(|fa_f);
      inf_b   = (&eb_f) & ~(|fb_f);
      zero_a  = ~(|ea_f) & ~(|fa_f);
      zero_b  = ~(|eb_f) & ~(|fb_f);
      sa_raw  = {|ea_f, fa_f};
      sb_raw  = {|eb_f, fb_f};
      la      = (|ea_f) ? '0 : lzc(sa_raw);
      lb      = (|eb_f) ? '0 : lzc(sb_raw);
      ma_n    = sa_raw << la;
      mb_n    = sb_raw << lb;
      ea_eff  = (|ea_f) ? XW'(ea_f) : XW'(1) - la;
      eb_eff  = (|eb_f) ? XW'(eb_f) : XW'(1) - lb;
      ma_lt   = ma_n < mb_n;
      exp_pre = ea_eff - eb_eff + XW'(BIAS) - XW'(ma_lt);
      rem_pre = ma_lt ? {ma_n, 1'b0} : {1'b0, ma_n};
   end

   logic [W-1:0] qnan, inf_res, zero_res, max_fin;
   assign qnan     = {1'b0, {EXP_W{1'b1}}, 1'b1, {(FRAC_W-1){1'b0}}};
   assign inf_res  = {sign_r, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
   assign zero_res = {sign_r, {(W-1){1'b0}}};
   assign max_fin  = {sign_r, {(EXP_W-1){1'b1}}, 1'b0, {FRAC_W{1'b1}}};

   logic         pre_special;
   logic [W-1:0] spec_result;
   logic [4:0]   spec_flags;

   always_comb begin
      pre_special = 1'b1;
      spec_result = zero_res;
      spec_flags  = '0;
      if (nan_a | nan_b) begin
         spec_result = qnan;
         spec_flags  = {snan_a | snan_b, 4'b0000};
      end else if ((zero_a & zero_b) | (inf_a & inf_b)) begin
         spec_result = qnan;
         spec_flags  = 5'b10000;
      end else if (inf_a) begin
         spec_result = inf_res;
      end else if (zero_b) begin
         spec_result = inf_res;
         spec_flags  = 5'b01000;
      end else if (zero_a | inf_b) begin
         spec_result = zero_res;
      end else begin
         pre_special = 1'b0;
      end
   end

   // Rounding of the M+2 quotient bits plus remainder sticky
   logic          rbit, sbit, inc, carry, ovf, unf, ovf_inf;
   logic [M-1:0]  frac_sum;
   logic [XW-1:0] exp_rnd;
   logic [W-1:0]  rnd_result;
   logic [4:0]    rnd_flags;

   always_comb begin
      rbit = quo_q[1];
      sbit = quo_q[0] | (|rem_q);
      case (rm_q)
         3'd1:    inc = 1'b0;
         3'd2:    inc = sign_r & (rbit | sbit);
         3'd3:    inc = ~sign_r & (rbit | sbit);
         3'd4:    inc = rbit;
         default: inc = rbit & (sbit | quo_q[2]);
      endcase
      case (rm_q)
         3'd1:    ovf_inf = 1'b0;
         3'd2:    ovf_inf = sign_r;
         3'd3:    ovf_inf = ~sign_r;
         default: ovf_inf = 1'b1;
      endcase
      // The hidden bit is always set here, so a fraction carry-out means 2.0
      frac_sum = {1'b0, quo_q[M:2]} + M'(inc);
      carry    = quo_q[M+1] & frac_sum[M-1];
      exp_rnd  = exp_q + XW'(carry);
      ovf      = ~exp_rnd[XW-1] & (exp_rnd[XW-2:0] >= {2'b00, {EXP_W{1'b1}}});
      unf      = exp_rnd[XW-1] | (exp_rnd == '0);
      if (ovf) begin
         rnd_result = ovf_inf ? inf_res : max_fin;
         rnd_flags  = 5'b00101;
      end else if (unf) begin
         rnd_result = zero_res;
         rnd_flags  = 5'b00011;
      end else begin
         rnd_result = {sign_r, exp_rnd[EXP_W-1:0], frac_sum[M-2:0]};
         rnd_flags  = {4'b0000, rbit | sbit};
      end
   end

   logic         rem_ge;
   logic [M:0]   rem_sub;

   always_comb begin
      a_d       = a_q;
      b_d       = b_q;
      rm_d      = rm_q;
      exp_d     = exp_q;
      mb_d      = mb_q;
      rem_d     = rem_q;
      quo_d     = quo_q;
      cnt_d     = cnt_q;
      special_d = special_q;
      result_d  = result_q;
      flags_d   = flags_q;
      rem_ge    = rem_q >= {1'b0, mb_q};
      rem_sub   = rem_ge ? rem_q - {1'b0, mb_q} : rem_q;
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               a_d  = a;
               b_d  = b;
               rm_d = rm;
            end
         end
         S_PRE: begin
            exp_d     = exp_pre;
            mb_d      = mb_n;
            rem_d     = rem_pre;
            quo_d     = '0;
            cnt_d     = '0;
            special_d = pre_special;
            if (pre_special) begin
               result_d = spec_result;
               flags_d  = spec_flags;
            end
         end
         S_DIV: begin
            rem_d = rem_sub << 1;
            quo_d = {quo_q[M:0], rem_ge};
            cnt_d = cnt_q + CNT_W'(1);
         end
         S_ROUND: begin
            if (!special_q) begin
               result_d = rnd_result;
               flags_d  = rnd_flags;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_q       <= '0;
         b_q       <= '0;
         rm_q      <= '0;
         exp_q     <= '0;
         mb_q      <= '0;
         rem_q     <= '0;
         quo_q     <= '0;
         cnt_q     <= '0;
         special_q <= 1'b0;
         result_q  <= '0;
         flags_q   <= '0;
      end else begin
         a_q       <= a_d;
         b_q       <= b_d;
         rm_q      <= rm_d;
         exp_q     <= exp_d;
         mb_q      <= mb_d;
         rem_q     <= rem_d;
         quo_q     <= quo_d;
         cnt_q     <= cnt_d;
         special_q <= special_d;
         result_q  <= result_d;
         flags_q   <= flags_d;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   // Special cases pass through ROUND so they finish two edges after accept
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (in_valid) state_d = S_PRE;
         S_PRE:   state_d = pre_special ? S_ROUND : S_DIV;
         S_DIV:   if (cnt_q == CNT_W'(M + 1)) state_d = S_ROUND;
         S_ROUND: state_d = S_DONE;
         S_DONE:  if (out_ready) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (state_q == S_IDLE);
      out_valid = (state_q == S_DONE);
      result    = result_q;
      flags     = flags_q;
   end

endmodule

// File: tb/tb_fp_div_iter.sv
// Bench for fp_div_iter in double and single configurations against an exact-arithmetic
// reference: directed cases, randomized operands, handshake stall and mid-operation reset.
module tb_fp_div_iter;

   logic        clk = 1'b0;
   logic        rst;
   always #5 clk = ~clk;

   logic        d_in_valid, d_in_ready, d_out_valid, d_out_ready;
   logic [63:0] d_a, d_b, d_result;
   logic [2:0]  d_rm;
   logic [4:0]  d_flags;
   logic        s_in_valid, s_in_ready, s_out_valid, s_out_ready;
   logic [31:0] s_a, s_b, s_result;
   logic [2:0]  s_rm;
   logic [4:0]  s_flags;

   fp_div_iter #(.EXP_W(11), .FRAC_W(52)) u_dbl (
      .clk(clk), .rst(rst), .in_valid(d_in_valid), .in_ready(d_in_ready),
      .a(d_a), .b(d_b), .rm(d_rm), .out_valid(d_out_valid), .out_ready(d_out_ready),
      .result(d_result), .flags(d_flags));

   fp_div_iter #(.EXP_W(8), .FRAC_W(23)) u_sgl (
      .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready),
      .a(s_a), .b(s_b), .rm(s_rm), .out_valid(s_out_valid), .out_ready(s_out_ready),
      .result(s_result), .flags(s_flags));

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   // Exact reference: value = m * 2^x, quotient by wide integer division, then IEEE rounding.
   // Returns {special, flags[4:0], result[63:0]}.
   function automatic logic [69:0] ref_div(input logic [63:0] a, input logic [63:0] b,
                                           input logic [2:0] rm, input int ew, input int fw);
      longint unsigned emask, fmask, ea, eb, fa, fb, ma, mb, qnan, inf, zero, maxf, sig, res;
      int bias, xa, xb, p, sh, e, s_amt;
      logic [191:0] num, q, rem;
      logic sg, na, nb, sna, snb, ia, ib, za, zb, r, s, inc;
      logic [4:0] fl;
      emask = (64'd1 << ew) - 64'd1;
      fmask = (64'd1 << fw) - 64'd1;
      bias  = (1 << (ew - 1)) - 1;
      sg    = a[ew+fw] ^ b[ew+fw];
      ea = (a >> fw) & emask;  eb = (b >> fw) & emask;
      fa = a & fmask;          fb = b & fmask;
      na  = (ea == emask) && (fa != 0);
      nb  = (eb == emask) && (fb != 0);
      sna = na && (((fa >> (fw - 1)) & 64'd1) == 0);
      snb = nb && (((fb >> (fw - 1)) & 64'd1) == 0);
      ia = (ea == emask) && (fa == 0);  ib = (eb == emask) && (fb == 0);
      za = (ea == 0) && (fa == 0);      zb = (eb == 0) && (fb == 0);
      zero = 64'(sg) << (ew + fw);
      inf  = zero | (emask << fw);
      maxf = zero | ((emask - 64'd1) << fw) | fmask;
      qnan = (emask << fw) | (64'd1 << (fw - 1));
      if (na || nb) return {1'b1, sna || snb, 4'b0000, qnan};
      if ((za && zb) || (ia && ib)) return {1'b1, 5'b10000, qnan};
      if (ia) return {1'b1, 5'b00000, inf};
      if (zb) return {1'b1, 5'b01000, inf};
      if (za || ib) return {1'b1, 5'b00000, zero};
      ma = (ea != 0) ? (fa | (64'd1 << fw)) : fa;
      mb = (eb != 0) ? (fb | (64'd1 << fw)) : fb;
      xa = ((ea != 0) ? int'(ea) : 1) - bias - fw;
      xb = ((eb != 0) ? int'(eb) : 1) - bias - fw;
      s_amt = 2 * fw + 4;
      num = 192'(ma) << s_amt;
      q   = num / 192'(mb);
      rem = num % 192'(mb);
      p = 0;
      for (int i = 0; i < 192; i++) if (q[i]) p = i;
      sh  = p - fw;
      sig = 64'(q >> sh);
      r   = q[sh-1];
      s   = (rem != 0) || ((q & ((192'd1 << (sh - 1)) - 192'd1)) != 0);
      e   = p + xa - xb - s_amt + bias;
      case (rm)
         3'd1:    inc = 1'b0;
         3'd2:    inc = sg & (r | s);
         3'd3:    inc = ~sg & (r | s);
         3'd4:    inc = r;
         default: inc = r & (s | sig[0]);
      endcase
      sig = sig + 64'(inc);
      if (sig == (64'd1 << (fw + 1))) begin
         sig = 64'd1 << fw;
         e++;
      end
      if (e >= int'(emask)) begin
         fl = 5'b00101;
         case (rm)
            3'd1:    res = maxf;
            3'd2:    res = sg ? inf : maxf;
            3'd3:    res = sg ? maxf : inf;
            default: res = inf;
         endcase
      end else if (e <= 0) begin
         fl  = 5'b00011;
         res = zero;
      end else begin
         fl  = {4'b0000, r | s};
         res = zero | (64'(e) << fw) | (sig & fmask);
      end
      return {1'b0, fl, res};
   endfunction

   function automatic logic [63:0] rand_op(input int ew, input int fw);
      longint unsigned emask, fmask, e, f, sg;
      emask = (64'd1 << ew) - 64'd1;
      fmask = (64'd1 << fw) - 64'd1;
      f  = {$urandom, $urandom} & fmask;
      sg = 64'($urandom_range(0, 1));
      case ($urandom_range(0, 11))
         0:       begin e = 0; f = 0; end
         1:       begin e = emask; f = 0; end
         2:       begin e = emask; if (f == 0) f = 1; end
         3:       begin e = 0; if (f == 0) f = 64'd1 << $urandom_range(0, fw - 1); end
         4:       e = emask - 64'd1 - 64'($urandom_range(0, 3));
         5:       e = 64'd1 + 64'($urandom_range(0, 3));
         default: e = 64'($urandom_range(1, 32'(emask - 64'd1)));
      endcase
      return (sg << (ew + fw)) | (e << fw) | f;
   endfunction

   task automatic op_d(input logic [63:0] a, input logic [63:0] b, input logic [2:0] rm,
                       input logic [69:0] ev, input int stall, input logic eager, input string tag);
      int lat;
      chk({tag, ".ready_idle"}, 64'(d_in_ready), 64'd1);
      d_a = a; d_b = b; d_rm = rm; d_in_valid = 1'b1;
      @(posedge clk); #1;
      d_in_valid = 1'b0;
      d_a = {$urandom, $urandom}; d_b = {$urandom, $urandom}; d_rm = 3'($urandom_range(0, 7));
      d_out_ready = eager;
      chk({tag, ".ready_busy"}, 64'(d_in_ready), 64'd0);
      lat = 0;
      while (d_out_valid !== 1'b1 && lat < 200) begin
         @(posedge clk); #1;
         lat++;
      end
      chk({tag, ".latency"}, 64'(lat), ev[69] ? 64'd2 : 64'd57);
      chk({tag, ".result"}, d_result, ev[63:0]);
      chk({tag, ".flags"}, 64'(d_flags), 64'(ev[68:64]));
      for (int i = 0; i < stall; i++) begin
         @(posedge clk); #1;
         chk({tag, ".stall_result"}, d_result, ev[63:0]);
         chk({tag, ".stall_ready"}, 64'(d_in_ready), 64'd0);
      end
      d_out_ready = 1'b1;
      @(posedge clk); #1;
      d_out_ready = 1'b0;
      chk({tag, ".valid_drop"}, 64'(d_out_valid), 64'd0);
      chk({tag, ".ready_back"}, 64'(d_in_ready), 64'd1);
   endtask

   task automatic op_s(input logic [31:0] a, input logic [31:0] b, input logic [2:0] rm,
                       input logic [69:0] ev, input logic eager, input string tag);
      int lat;
      chk({tag, ".ready_idle"}, 64'(s_in_ready), 64'd1);
      s_a = a; s_b = b; s_rm = rm; s_in_valid = 1'b1;
      @(posedge clk); #1;
      s_in_valid = 1'b0;
      s_a = $urandom; s_b = $urandom; s_rm = 3'($urandom_range(0, 7));
      s_out_ready = eager;
      lat = 0;
      while (s_out_valid !== 1'b1 && lat < 200) begin
         @(posedge clk); #1;
         lat++;
      end
      chk({tag, ".latency"}, 64'(lat), ev[69] ? 64'd2 : 64'd28);
      chk({tag, ".result"}, 64'(s_result), 64'(ev[31:0]));
      chk({tag, ".flags"}, 64'(s_flags), 64'(ev[68:64]));
      s_out_ready = 1'b1;
      @(posedge clk); #1;
      s_out_ready = 1'b0;
      chk({tag, ".ready_back"}, 64'(s_in_ready), 64'd1);
   endtask

   initial begin
      logic [63:0] ra, rb;
      logic [2:0]  rrm;
      rst = 1'b1;
      d_in_valid = 1'b0; d_out_ready = 1'b0; d_a = '0; d_b = '0; d_rm = '0;
      s_in_valid = 1'b0; s_out_ready = 1'b0; s_a = '0; s_b = '0; s_rm = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      chk("rst.d_ready", 64'(d_in_ready), 64'd1);
      chk("rst.d_valid", 64'(d_out_valid), 64'd0);
      chk("rst.d_result", d_result, 64'd0);
      chk("rst.d_flags", 64'(d_flags), 64'd0);
      chk("rst.s_ready", 64'(s_in_ready), 64'd1);
      chk("rst.s_valid", 64'(s_out_valid), 64'd0);

      op_d(64'h4018000000000000, 64'h4000000000000000, 3'd0, {1'b0, 5'b00000, 64'h4008000000000000}, 0, 1'b0, "d_6div2");
      op_d(64'h3FF0000000000000, 64'h4008000000000000, 3'd0, {1'b0, 5'b00001, 64'h3FD5555555555555}, 0, 1'b0, "d_third_rne");
      op_d(64'h3FF0000000000000, 64'h4008000000000000, 3'd3, {1'b0, 5'b00001, 64'h3FD5555555555556}, 0, 1'b0, "d_third_rup");
      op_d(64'h3FF0000000000000, 64'h0000000000000000, 3'd0, {1'b1, 5'b01000, 64'h7FF0000000000000}, 0, 1'b0, "d_div0");
      op_d(64'h0000000000000000, 64'h0000000000000000, 3'd0, {1'b1, 5'b10000, 64'h7FF8000000000000}, 0, 1'b0, "d_0div0");
      op_d(64'h7FF0000000000001, 64'h3FF0000000000000, 3'd0, {1'b1, 5'b10000, 64'h7FF8000000000000}, 0, 1'b0, "d_snan");
      op_d(64'h7FEFFFFFFFFFFFFF, 64'h3FE0000000000000, 3'd0, {1'b0, 5'b00101, 64'h7FF0000000000000}, 0, 1'b0, "d_ovf_rne");
      op_d(64'h7FEFFFFFFFFFFFFF, 64'h3FE0000000000000, 3'd1, {1'b0, 5'b00101, 64'h7FEFFFFFFFFFFFFF}, 0, 1'b0, "d_ovf_rtz");
      op_d(64'hFFEFFFFFFFFFFFFF, 64'h3FE0000000000000, 3'd2, {1'b0, 5'b00101, 64'hFFF0000000000000}, 0, 1'b0, "d_ovf_rdn_neg");
      op_d(64'hFFEFFFFFFFFFFFFF, 64'h3FE0000000000000, 3'd3, {1'b0, 5'b00101, 64'hFFEFFFFFFFFFFFFF}, 0, 1'b0, "d_ovf_rup_neg");
      op_d(64'h0010000000000000, 64'h4000000000000000, 3'd0, {1'b0, 5'b00011, 64'h0000000000000000}, 0, 1'b0, "d_unf");
      op_d(64'h0000000000000001, 64'h0000000000000001, 3'd0, {1'b0, 5'b00000, 64'h3FF0000000000000}, 0, 1'b0, "d_subn");
      op_d(64'h3FF0000000000000, 64'h4008000000000000, 3'd0, {1'b0, 5'b00001, 64'h3FD5555555555555}, 10, 1'b0, "d_stall");
      op_s(32'h3F800000, 32'h40400000, 3'd0, {1'b0, 5'b00001, 32'h0, 32'h3EAAAAAB}, 1'b0, "s_third");

      // Reset in the middle of DIV aborts the operation
      d_a = 64'h3FF0000000000000; d_b = 64'h4008000000000000; d_rm = 3'd0; d_in_valid = 1'b1;
      @(posedge clk); #1;
      d_in_valid = 1'b0;
      repeat (20) @(posedge clk);
      #1;
      chk("abort.busy", 64'(d_in_ready), 64'd0);
      rst = 1'b1;
      #1;
      chk("abort.valid", 64'(d_out_valid), 64'd0);
      chk("abort.ready_async", 64'(d_in_ready), 64'd1);
      chk("abort.result", d_result, 64'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      chk("abort.ready_after", 64'(d_in_ready), 64'd1);
      repeat (60) @(posedge clk);
      #1;
      chk("abort.no_result", 64'(d_out_valid), 64'd0);

      for (int n = 0; n < 40; n++) begin
         ra = rand_op(11, 52); rb = rand_op(11, 52); rrm = 3'($urandom_range(0, 7));
         op_d(ra, rb, rrm, ref_div(ra, rb, rrm, 11, 52), 0, 1'($urandom_range(0, 1)), "d_rnd");
      end
      for (int n = 0; n < 40; n++) begin
         ra = rand_op(8, 23); rb = rand_op(8, 23); rrm = 3'($urandom_range(0, 7));
         op_s(ra[31:0], rb[31:0], rrm, ref_div(ra, rb, rrm, 8, 23), 1'($urandom_range(0, 1)), "s_rnd");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
